// File: rtl/gray_sync_checker.sv
// Synchronizes an asynchronous Gray-coded counter, converts it to binary and
// supervises its stepping: locks after a run of +1 steps, flags errors once locked.
module gray_sync_checker #(
    parameter int unsigned BITS        = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_STEPS  = 4,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned ERR_BITS    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITS-1:0]     gray_in,
    output logic [BITS-1:0]     binary_out,
    output logic                step_up,
    output logic                step_error,
    output logic                locked,
    output logic [ERR_BITS-1:0] err_count
);

    localparam int unsigned IDLE_W = $clog2(SYNC_STAGES + 2);
    localparam int unsigned GOOD_W = $clog2(LOCK_STEPS + 1);
    localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(SYNC_STAGES);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_STEPS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0][BITS-1:0] sync_q, sync_d;
    logic [BITS-1:0]     binary_out_q, binary_out_d;
    logic [BITS-1:0]     prev_bin_q, prev_bin_d;
    logic                step_up_q, step_up_d;
    logic                step_error_q, step_error_d;
    logic                locked_q, locked_d;
    logic [ERR_BITS-1:0] err_count_q, err_count_d;
    logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [GOOD_W-1:0]   good_cnt_q, good_cnt_d;
    logic [TMR_W-1:0]    stall_q, stall_d;

    logic [BITS-1:0] cur_c;
    logic [BITS-1:0] bin_cur_c;
    logic [BITS-1:0] delta_c;
    logic            is_same_c;
    logic            is_up_c;
    logic            lock_err_c;

    // Synchronizer shift chain; the last stage is the sampled value
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], gray_in};
    end

    assign cur_c = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        logic run;
        run       = 1'b0;
        bin_cur_c = '0;
        for (int i = int'(BITS) - 1; i >= 0; i--) begin
            run          = run ^ cur_c[i];
            bin_cur_c[i] = run;
        end
    end

    // Modular difference makes the wrap cases fall out naturally
    assign delta_c   = bin_cur_c - prev_bin_q;
    assign is_same_c = (delta_c == '0);
    assign is_up_c   = (delta_c == BITS'(1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and supervision counters
    always_comb begin
        state_d    = state_q;
        idle_cnt_d = idle_cnt_q;
        good_cnt_d = good_cnt_q;
        stall_d    = stall_q;
        lock_err_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (idle_cnt_q == IDLE_LAST) begin
                    state_d    = ST_ACQUIRE;
                    idle_cnt_d = '0;
                    good_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            ST_ACQUIRE: begin
                stall_d = '0;
                if (is_up_c) begin
                    if (good_cnt_q == GOOD_LAST) begin
                        state_d    = ST_LOCKED;
                        good_cnt_d = '0;
                    end else begin
                        good_cnt_d = good_cnt_q + GOOD_W'(1);
                    end
                end else if (!is_same_c) begin
                    good_cnt_d = '0;
                end
            end
            ST_LOCKED: begin
                // A change always beats a coinciding stall
                if (is_up_c) begin
                    stall_d = '0;
                end else if (is_same_c) begin
                    if (stall_q == TMR_LAST) begin
                        lock_err_c = 1'b1;
                    end else begin
                        stall_d = stall_q + TMR_W'(1);
                    end
                end else begin
                    lock_err_c = 1'b1;
                end
                if (lock_err_c) begin
                    state_d    = ST_ACQUIRE;
                    good_cnt_d = '0;
                    stall_d    = '0;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                idle_cnt_d = '0;
                good_cnt_d = '0;
                stall_d    = '0;
            end
        endcase
    end

    // Output values, all registered alongside the state
    always_comb begin
        binary_out_d = bin_cur_c;
        prev_bin_d   = bin_cur_c;
        step_up_d    = (state_q != ST_IDLE) && is_up_c;
        step_error_d = lock_err_c;
        locked_d     = (state_d == ST_LOCKED);
        err_count_d  = err_count_q;
        if (lock_err_c && (err_count_q != '1)) begin
            err_count_d = err_count_q + ERR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            binary_out_q <= '0;
            prev_bin_q   <= '0;
            step_up_q    <= 1'b0;
            step_error_q <= 1'b0;
            locked_q     <= 1'b0;
            err_count_q  <= '0;
            idle_cnt_q   <= '0;
            good_cnt_q   <= '0;
            stall_q      <= '0;
        end else begin
            sync_q       <= sync_d;
            binary_out_q <= binary_out_d;
            prev_bin_q   <= prev_bin_d;
            step_up_q    <= step_up_d;
            step_error_q <= step_error_d;
            locked_q     <= locked_d;
            err_count_q  <= err_count_d;
            idle_cnt_q   <= idle_cnt_d;
            good_cnt_q   <= good_cnt_d;
            stall_q      <= stall_d;
        end
    end

    assign binary_out = binary_out_q;
    assign step_up    = step_up_q;
    assign step_error = step_error_q;
    assign locked     = locked_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_gray_sync_checker.sv
// Scoreboard bench for gray_sync_checker: a reference model predicts every cycle's
// outputs from the applied Gray sequence; a monitor compares them against the DUT.
module tb_gray_sync_checker;

    localparam int BITS = 8;
    localparam int S    = 2;
    localparam int LOCK = 4;
    localparam int TMO  = 64;
    localparam int EB   = 2;
    localparam int EMAX = 3;

    localparam int M_IDLE = 0;
    localparam int M_ACQ  = 1;
    localparam int M_LOCK = 2;

    logic            clk;
    logic            rst_n;
    logic [7:0]      gray_in;
    logic [7:0]      binary_out;
    logic            step_up;
    logic            step_error;
    logic            locked;
    logic [EB-1:0]   err_count;

    gray_sync_checker #(
        .BITS(BITS), .SYNC_STAGES(S), .LOCK_STEPS(LOCK), .TIMEOUT(TMO), .ERR_BITS(EB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .gray_in(gray_in), .binary_out(binary_out),
        .step_up(step_up), .step_error(step_error), .locked(locked), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] bin;
        logic       up;
        logic       err;
        logic       lk;
        logic [1:0] ec;
    } exp_t;

    exp_t exp_q[$];
    int   dq[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    bit   mon_en  = 0;

    int m_mode, m_idle_left, m_good, m_quiet, m_errs;
    int rb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    function automatic logic [7:0] gray(input int n);
        int m;
        m = n & 255;
        return 8'(m ^ (m >> 1));
    endfunction

    function automatic logic [7:0] g2b(input logic [7:0] g);
        logic [7:0] b;
        b = g;
        for (int i = 1; i < 8; i++) b = b ^ (g >> i);
        return b;
    endfunction

    task automatic model_reset();
        dq.delete();
        for (int i = 0; i < S + 1; i++) dq.push_back(0);
        m_mode = M_IDLE; m_idle_left = S + 1; m_good = 0; m_quiet = 0; m_errs = 0;
    endtask

    // Predicts the outputs right after the clock edge that follows this drive
    task automatic model_step(input logic [7:0] g);
        exp_t e;
        int   nb, ob, d;
        bit   err;
        dq.push_back(int'(g2b(g)));
        nb = dq[dq.size() - 1 - S];
        ob = dq[dq.size() - 2 - S];
        void'(dq.pop_front());
        err  = 0;
        e.up = 0;
        d    = (nb - ob + 256) % 256;
        if (m_mode == M_IDLE) begin
            m_idle_left--;
            if (m_idle_left == 0) begin m_mode = M_ACQ; m_good = 0; end
        end else if (m_mode == M_ACQ) begin
            if (d == 1) begin
                e.up = 1; m_good++;
                if (m_good == LOCK) begin m_mode = M_LOCK; m_quiet = 0; end
            end else if (d != 0) begin
                m_good = 0;
            end
        end else begin
            if (d == 1) begin e.up = 1; m_quiet = 0; end
            else if (d == 0) begin m_quiet++; if (m_quiet == TMO) err = 1; end
            else err = 1;
            if (err) begin
                if (m_errs < EMAX) m_errs++;
                m_mode = M_ACQ; m_good = 0; m_quiet = 0;
            end
        end
        e.bin = 8'(nb);
        e.err = err;
        e.lk  = (m_mode == M_LOCK);
        e.ec  = 2'(m_errs);
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs with the oldest prediction after every edge
    always @(posedge clk) begin
        if (mon_en) begin
            #1;
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("binary_out", 32'(binary_out), 32'(e.bin));
                chk("step_up",    32'(step_up),    32'(e.up));
                chk("step_error", 32'(step_error), 32'(e.err));
                chk("locked",     32'(locked),     32'(e.lk));
                chk("err_count",  32'(err_count),  32'(e.ec));
            end
        end
    end

    task automatic tick(input logic [7:0] g);
        @(negedge clk);
        gray_in = g;
        model_step(g);
    endtask

    task automatic hold(input logic [7:0] g, input int n);
        repeat (n) tick(g);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_binary_out"}, 32'(binary_out), 32'd0);
        chk({tag, "_step_up"},    32'(step_up),    32'd0);
        chk({tag, "_step_error"}, 32'(step_error), 32'd0);
        chk({tag, "_locked"},     32'(locked),     32'd0);
        chk({tag, "_err_count"},  32'(err_count),  32'd0);
    endtask

    task automatic up_run(input int steps, input int each);
        for (int k = 0; k < steps; k++) begin
            rb = (rb + 1) & 255;
            hold(gray(rb), each);
        end
    endtask

    initial begin
        int hold_n;
        int r;
        rst_n   = 1'b0;
        gray_in = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("in_reset");
        #1;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1;

        // Quiet input after reset: nothing happens, no lock, no errors
        hold(8'h00, 80);
        settle();
        chk("idle_err_count", 32'(err_count), 32'd0);
        chk("idle_locked",    32'(locked),    32'd0);

        // Gray up-count to binary 4 locks on the fourth step
        hold(8'h01, 16); hold(8'h03, 16); hold(8'h02, 16); hold(8'h06, 16);
        settle();
        chk("lock_locked", 32'(locked),     32'd1);
        chk("lock_binary", 32'(binary_out), 32'h04);

        // Multi-bit jump while locked
        hold(8'h0F, 8);
        settle();
        chk("jump_err_count", 32'(err_count),  32'd1);
        chk("jump_locked",    32'(locked),     32'd0);
        chk("jump_binary",    32'(binary_out), 32'h0A);

        // Relock, then stall
        rb = 10;
        up_run(4, 4);
        hold(gray(rb), 70);
        settle();
        chk("stall_err_count", 32'(err_count), 32'd2);
        chk("stall_locked",    32'(locked),    32'd0);

        // Wrap 255 -> 0 is a legal up step
        rb = 249;
        up_run(8, 3);
        settle();
        chk("wrap_locked",    32'(locked),     32'd1);
        chk("wrap_err_count", 32'(err_count),  32'd2);
        chk("wrap_binary",    32'(binary_out), 32'h01);

        // Force three more errors; the 2-bit counter must saturate at 3
        repeat (3) begin
            up_run(4, 3);
            rb = (rb + 100) & 255;
            hold(gray(rb), 4);
        end
        settle();
        chk("sat_err_count", 32'(err_count), 32'd3);

        // Randomized stepping: mostly up, some down, jumps and long stalls
        for (int it = 0; it < 1200; it++) begin
            r = $urandom_range(0, 19);
            hold_n = $urandom_range(1, 5);
            if (r < 14)      rb = (rb + 1) & 255;
            else if (r < 16) rb = (rb + 255) & 255;
            else if (r < 18) rb = (rb + $urandom_range(2, 254)) & 255;
            else if (r == 18) hold_n = $urandom_range(60, 70);
            hold(gray(rb), hold_n);
        end

        // Asynchronous reset in the middle of LOCKED
        up_run(5, 3);
        settle();
        chk("pre_reset_locked", 32'(locked), 32'd1);
        mon_en = 0;
        rst_n  = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        model_reset();
        mon_en = 1;
        hold(8'h00, 20);
        settle();
        chk("post_reset_err_count", 32'(err_count), 32'd0);
        mon_en = 0;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
